// File: rtl/dircc_processing_mem_mp.sv
// Dual-port Avalon-MM byte-enabled memory; port B is a RATIO-times narrower view of port A.
// Optional post-reset zero-fill of the array is enabled by defining DIRCC_PMEM_ZERO_INIT_EN.

module dircc_pmem_rd_pipe #(
  parameter int W   = 32,
  parameter int LAT = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         acc_i,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  output logic [W-1:0] data_o
);
  logic         v1_q;
  logic [W-1:0] d1_q;

  // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q <= 1'b0;
      d1_q <= '0;
    end else begin
      v1_q <= acc_i;
      if (acc_i) d1_q <= data_i;
    end
  end

  if (LAT == 2) begin : g_lat2
    logic         v2_q;
    logic [W-1:0] d2_q;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        v2_q <= 1'b0;
        d2_q <= '0;
      end else begin
        v2_q <= v1_q;
        if (v1_q) d2_q <= d1_q;
      end
    end
    assign valid_o = v2_q;
    assign data_o  = d2_q;
  end else begin : g_lat1
    assign valid_o = v1_q;
    assign data_o  = d1_q;
  end
endmodule

module dircc_processing_mem_mp #(
  parameter int  DATA_W       = 32,
  parameter int  RATIO        = 2,
  parameter int  DEPTH_A      = 5000,
  parameter int  READ_LATENCY = 1,
  localparam int BW           = DATA_W / RATIO,
  localparam int NB_A         = DATA_W / 8,
  localparam int NB_B         = BW / 8,
  localparam int AW_A         = $clog2(DEPTH_A),
  localparam int AW_B         = $clog2(DEPTH_A * RATIO)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              freeze,
  input  logic              a_chipselect,
  input  logic              a_read,
  input  logic              a_write,
  input  logic [AW_A-1:0]   a_address,
  input  logic [NB_A-1:0]   a_byteenable,
  input  logic [DATA_W-1:0] a_writedata,
  output logic [DATA_W-1:0] a_readdata,
  output logic              a_readdatavalid,
  output logic              a_waitrequest,
  input  logic              b_chipselect,
  input  logic              b_read,
  input  logic              b_write,
  input  logic [AW_B-1:0]   b_address,
  input  logic [NB_B-1:0]   b_byteenable,
  input  logic [BW-1:0]     b_writedata,
  output logic [BW-1:0]     b_readdata,
  output logic              b_readdatavalid,
  output logic              b_waitrequest,
  output logic              init_done,
  output logic              err_oor
);
`ifdef DIRCC_PMEM_ZERO_INIT_EN
  typedef enum logic [1:0] {ST_RST, ST_INIT, ST_READY} state_e;
  logic [AW_A-1:0] init_cnt_q, init_cnt_d;
`else
  typedef enum logic [1:0] {ST_RST, ST_READY} state_e;
`endif

  state_e            state_q, state_d;
  logic              freeze_q, err_oor_q, err_oor_d;
  logic [DATA_W-1:0] mem_q [DEPTH_A];

  logic              base_wait;
  logic              a_in, a_acc, a_wr_acc, a_rd_acc;
  logic              b_in, b_acc, b_wr_acc, b_rd_acc, conflict;
  logic [AW_A-1:0]   b_word;
  int                b_lane;
  logic [NB_A-1:0]   b_be_full;
  logic [DATA_W-1:0] b_wdata_full, b_word_data, a_rdata;
  logic [BW-1:0]     b_rdata;

  // Freeze takes effect one cycle after it is seen, so it is registered.
  assign base_wait = (state_q != ST_READY) | freeze_q;

  assign a_in          = int'(a_address) < DEPTH_A;
  assign a_waitrequest = base_wait;
  assign a_acc         = a_chipselect & (a_read | a_write) & ~a_waitrequest;
  assign a_wr_acc      = a_acc & a_write;
  assign a_rd_acc      = a_acc & ~a_write;

  // Port B word k lives in port A word k/RATIO, lane k%RATIO (lane 0 = LSBs).
  assign b_word       = AW_A'(b_address / AW_B'(RATIO));
  assign b_lane       = int'(b_address % AW_B'(RATIO));
  assign b_in         = int'(b_address) < DEPTH_A * RATIO;
  assign b_be_full    = NB_A'(b_byteenable) << (b_lane * NB_B);
  assign b_wdata_full = DATA_W'(b_writedata) << (b_lane * BW);

  // Overlapping same-word writes: port A proceeds, port B is stalled and retries.
  assign conflict = a_wr_acc & a_in & b_chipselect & b_write & b_in &
                    (b_word == a_address) & (|(a_byteenable & b_be_full));
  assign b_waitrequest = base_wait | conflict;
  assign b_acc         = b_chipselect & (b_read | b_write) & ~b_waitrequest;
  assign b_wr_acc      = b_acc & b_write;
  assign b_rd_acc      = b_acc & ~b_write;

  assign a_rdata     = a_in ? mem_q[a_address] : '0;
  assign b_word_data = mem_q[b_word];
  assign b_rdata     = b_in ? BW'(b_word_data >> (b_lane * BW)) : '0;

  // NOTE: storage deliberately has no reset; only the optional zero-fill clears it.
  always_ff @(posedge clk) begin
`ifdef DIRCC_PMEM_ZERO_INIT_EN
    if (state_q == ST_INIT) mem_q[init_cnt_q] <= '0;
`endif
    for (int i = 0; i < NB_A; i++) begin
      if (a_wr_acc && a_in && a_byteenable[i]) mem_q[a_address][i*8 +: 8] <= a_writedata[i*8 +: 8];
      if (b_wr_acc && b_in && b_be_full[i])    mem_q[b_word][i*8 +: 8]    <= b_wdata_full[i*8 +: 8];
    end
  end

  // NOTE: defaults first so no path leaves a signal unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    err_oor_d = err_oor_q;
`ifdef DIRCC_PMEM_ZERO_INIT_EN
    init_cnt_d = init_cnt_q;
`endif
    unique case (state_q)
`ifdef DIRCC_PMEM_ZERO_INIT_EN
      ST_RST: begin
        state_d    = ST_INIT;
        init_cnt_d = '0;
      end
      ST_INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == AW_A'(DEPTH_A - 1)) state_d = ST_READY;
      end
`else
      ST_RST: state_d = ST_READY;
`endif
      default: ;
    endcase
    if ((a_acc && !a_in) || (b_acc && !b_in)) err_oor_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_RST;
      freeze_q  <= 1'b0;
      err_oor_q <= 1'b0;
`ifdef DIRCC_PMEM_ZERO_INIT_EN
      init_cnt_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      freeze_q  <= freeze;
      err_oor_q <= err_oor_d;
`ifdef DIRCC_PMEM_ZERO_INIT_EN
      init_cnt_q <= init_cnt_d;
`endif
    end
  end

  assign init_done = (state_q == ST_READY);
  assign err_oor   = err_oor_q;

  dircc_pmem_rd_pipe #(.W(DATA_W), .LAT(READ_LATENCY)) u_rd_a (
    .clk(clk), .reset_n(reset_n), .acc_i(a_rd_acc), .data_i(a_rdata),
    .valid_o(a_readdatavalid), .data_o(a_readdata)
  );

  dircc_pmem_rd_pipe #(.W(BW), .LAT(READ_LATENCY)) u_rd_b (
    .clk(clk), .reset_n(reset_n), .acc_i(b_rd_acc), .data_i(b_rdata),
    .valid_o(b_readdatavalid), .data_o(b_readdata)
  );
endmodule

// File: tb/tb_dircc_processing_mem_mp.sv
// Directed bench for dircc_processing_mem_mp (DATA_W=32, RATIO=2, READ_LATENCY=2).
// Builds with or without DIRCC_PMEM_ZERO_INIT_EN; DEPTH_A is 16 with it, 5000 without.

module tb_dircc_processing_mem_mp;
  localparam int DW    = 32;
  localparam int RATIO = 2;
  localparam int RL    = 2;
`ifdef DIRCC_PMEM_ZERO_INIT_EN
  localparam int          DEPTH     = 16;
  localparam logic [31:0] PRESERVED = 32'h0000_0000;
`else
  localparam int          DEPTH     = 5000;
  localparam logic [31:0] PRESERVED = 32'hCAFE_F00D;
`endif
  localparam int BW  = DW / RATIO;
  localparam int AWA = $clog2(DEPTH);
  localparam int AWB = $clog2(DEPTH * RATIO);

  logic           clk = 1'b0, reset_n = 1'b0, freeze = 1'b0;
  logic           a_chipselect = 1'b0, a_read = 1'b0, a_write = 1'b0;
  logic [AWA-1:0] a_address = '0;
  logic [3:0]     a_byteenable = '0;
  logic [DW-1:0]  a_writedata = '0, a_readdata;
  logic           a_readdatavalid, a_waitrequest;
  logic           b_chipselect = 1'b0, b_read = 1'b0, b_write = 1'b0;
  logic [AWB-1:0] b_address = '0;
  logic [1:0]     b_byteenable = '0;
  logic [BW-1:0]  b_writedata = '0, b_readdata;
  logic           b_readdatavalid, b_waitrequest;
  logic           init_done, err_oor;

  int          checks = 0;
  int          errors = 0;
  int          pulses;
  logic [31:0] pulse_data [4];

  always #5 clk = ~clk;

  dircc_processing_mem_mp #(.DATA_W(DW), .RATIO(RATIO), .DEPTH_A(DEPTH), .READ_LATENCY(RL)) dut (
    .clk(clk), .reset_n(reset_n), .freeze(freeze),
    .a_chipselect(a_chipselect), .a_read(a_read), .a_write(a_write), .a_address(a_address),
    .a_byteenable(a_byteenable), .a_writedata(a_writedata), .a_readdata(a_readdata),
    .a_readdatavalid(a_readdatavalid), .a_waitrequest(a_waitrequest),
    .b_chipselect(b_chipselect), .b_read(b_read), .b_write(b_write), .b_address(b_address),
    .b_byteenable(b_byteenable), .b_writedata(b_writedata), .b_readdata(b_readdata),
    .b_readdatavalid(b_readdatavalid), .b_waitrequest(b_waitrequest),
    .init_done(init_done), .err_oor(err_oor)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    a_chipselect = 1'b0; a_read = 1'b0; a_write = 1'b0;
    b_chipselect = 1'b0; b_read = 1'b0; b_write = 1'b0;
  endtask

  task automatic a_wr(input logic [AWA-1:0] addr, input logic [3:0] be, input logic [31:0] data);
    a_chipselect = 1'b1; a_write = 1'b1; a_address = addr; a_byteenable = be; a_writedata = data;
    tick();
    idle();
  endtask

  task automatic b_wr(input logic [AWB-1:0] addr, input logic [1:0] be, input logic [15:0] data);
    b_chipselect = 1'b1; b_write = 1'b1; b_address = addr; b_byteenable = be; b_writedata = data;
    tick();
    idle();
  endtask

  // Issues one read and returns what the port shows RL cycles after acceptance.
  task automatic a_rd(input logic [AWA-1:0] addr, output logic valid, output logic [31:0] data);
    a_chipselect = 1'b1; a_read = 1'b1; a_address = addr;
    tick();
    idle();
    repeat (RL - 1) tick();
    valid = a_readdatavalid;
    data  = a_readdata;
  endtask

  task automatic b_rd(input logic [AWB-1:0] addr, output logic valid, output logic [15:0] data);
    b_chipselect = 1'b1; b_read = 1'b1; b_address = addr;
    tick();
    idle();
    repeat (RL - 1) tick();
    valid = b_readdatavalid;
    data  = b_readdata;
  endtask

  task automatic release_reset();
    reset_n = 1'b1;
    tick();
    for (int k = 0; k < DEPTH + 8 && init_done !== 1'b1; k++) tick();
    checks++;
    if (init_done !== 1'b1) begin errors++; $display("FAIL init_done_timeout: got %b expected 1", init_done); end
  endtask

  task automatic note_a_pulse();
    if (a_readdatavalid === 1'b1) begin
      if (pulses < 4) pulse_data[pulses] = a_readdata;
      pulses++;
    end
  endtask

  task automatic test_reset();
    int wr_cycles;
    tick(); tick();
    checks++;
    if ({a_readdatavalid, b_readdatavalid, a_waitrequest, b_waitrequest, init_done, err_oor} !== 6'b001100) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 001100",
               {a_readdatavalid, b_readdatavalid, a_waitrequest, b_waitrequest, init_done, err_oor});
    end
    checks++;
    if ({a_readdata, b_readdata} !== 48'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", {a_readdata, b_readdata}); end
`ifdef DIRCC_PMEM_ZERO_INIT_EN
    reset_n = 1'b1;
    repeat (8) tick();
    checks++;
    if (init_done !== 1'b0) begin errors++; $display("FAIL init_mid: got %b expected 0", init_done); end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({a_waitrequest, init_done} !== 2'b10) begin errors++; $display("FAIL init_rereset: got %b expected 10", {a_waitrequest, init_done}); end
    tick();
    reset_n = 1'b1;
    wr_cycles = 0;
    for (int k = 1; k <= DEPTH + 1; k++) begin
      tick();
      if (k <= DEPTH && a_waitrequest === 1'b1 && b_waitrequest === 1'b1 && init_done === 1'b0) wr_cycles++;
    end
    checks++;
    if (wr_cycles != DEPTH) begin errors++; $display("FAIL init_wait_cycles: got %0d expected %0d", wr_cycles, DEPTH); end
`else
    reset_n = 1'b1;
    tick();
`endif
    checks++;
    if ({init_done, a_waitrequest, b_waitrequest} !== 3'b100) begin
      errors++; $display("FAIL ready_after_reset: got %b expected 100", {init_done, a_waitrequest, b_waitrequest});
    end
  endtask

`ifdef DIRCC_PMEM_ZERO_INIT_EN
  task automatic test_zero_fill();
    logic v; logic [31:0] d;
    for (int w = 0; w < DEPTH; w++) begin
      a_rd(AWA'(w), v, d);
      checks++;
      if ({v, d} !== 33'h1_0000_0000) begin errors++; $display("FAIL zero_fill_w%0d: got %b/%h expected 1/0", w, v, d); end
    end
  endtask
`endif

  // Wide write then two back-to-back narrow reads of both lanes.
  task automatic test_back_to_back();
    a_wr(3, 4'hF, 32'hDEAD_BEEF);
    b_chipselect = 1'b1; b_read = 1'b1; b_address = 6;
    tick();
    checks++;
    if (b_readdatavalid !== 1'b0) begin errors++; $display("FAIL b2b_early: got %b expected 0", b_readdatavalid); end
    b_address = 7;
    tick();
    idle();
    checks++;
    if ({b_readdatavalid, b_readdata} !== 17'h1_BEEF) begin errors++; $display("FAIL b2b_lane0: got %h expected 1beef", {b_readdatavalid, b_readdata}); end
    tick();
    checks++;
    if ({b_readdatavalid, b_readdata} !== 17'h1_DEAD) begin errors++; $display("FAIL b2b_lane1: got %h expected 1dead", {b_readdatavalid, b_readdata}); end
    tick();
    checks++;
    if ({b_readdatavalid, b_readdata} !== 17'h0_DEAD) begin errors++; $display("FAIL b2b_hold: got %h expected 0dead", {b_readdatavalid, b_readdata}); end
  endtask

  task automatic test_byte_enable();
    logic v; logic [31:0] d; logic [15:0] h;
    a_wr(4, 4'hF, 32'h0);
    a_wr(4, 4'h5, 32'hAABB_CCDD);
    a_rd(4, v, d);
    checks++;
    if ({v, d} !== 33'h1_00BB_00DD) begin errors++; $display("FAIL be_a: got %h expected 100bb00dd", {v, d}); end
    b_wr(9, 2'b10, 16'h1234);
    a_rd(4, v, d);
    checks++;
    if ({v, d} !== 33'h1_12BB_00DD) begin errors++; $display("FAIL be_b: got %h expected 112bb00dd", {v, d}); end
    b_rd(8, v, h);
    checks++;
    if ({v, h} !== 17'h1_00DD) begin errors++; $display("FAIL be_b_rd: got %h expected 100dd", {v, h}); end
  endtask

  task automatic test_conflict();
    logic v; logic [31:0] d;
    a_wr(5, 4'hF, 32'h0);
    a_chipselect = 1'b1; a_write = 1'b1; a_address = 5; a_byteenable = 4'h3; a_writedata = 32'h1111_2222;
    b_chipselect = 1'b1; b_write = 1'b1; b_address = 10; b_byteenable = 2'b11; b_writedata = 16'h3333;
    #1;
    checks++;
    if ({a_waitrequest, b_waitrequest} !== 2'b01) begin errors++; $display("FAIL conflict_wait: got %b expected 01", {a_waitrequest, b_waitrequest}); end
    tick();
    a_chipselect = 1'b0; a_write = 1'b0;
    #1;
    checks++;
    if (b_waitrequest !== 1'b0) begin errors++; $display("FAIL conflict_retry: got %b expected 0", b_waitrequest); end
    tick();
    idle();
    a_rd(5, v, d);
    checks++;
    if ({v, d} !== 33'h1_0000_3333) begin errors++; $display("FAIL conflict_data: got %h expected 100003333", {v, d}); end
    // Same word, disjoint bytes: both writes land together.
    a_chipselect = 1'b1; a_write = 1'b1; a_address = 5; a_byteenable = 4'h1; a_writedata = 32'h0000_00AA;
    b_chipselect = 1'b1; b_write = 1'b1; b_address = 10; b_byteenable = 2'b10; b_writedata = 16'hBB00;
    #1;
    checks++;
    if (b_waitrequest !== 1'b0) begin errors++; $display("FAIL disjoint_wait: got %b expected 0", b_waitrequest); end
    tick();
    idle();
    a_rd(5, v, d);
    checks++;
    if ({v, d} !== 33'h1_0000_BBAA) begin errors++; $display("FAIL disjoint_data: got %h expected 10000bbaa", {v, d}); end
  endtask

  task automatic test_rw_same_cycle();
    logic v; logic [31:0] d;
    a_wr(7, 4'hF, 32'h0102_0304);
    a_chipselect = 1'b1; a_write = 1'b1; a_address = 7; a_byteenable = 4'hF; a_writedata = 32'hFFFF_FFFF;
    b_chipselect = 1'b1; b_read = 1'b1; b_address = 14;
    tick();
    idle();
    repeat (RL - 1) tick();
    checks++;
    if ({b_readdatavalid, b_readdata} !== 17'h1_0304) begin errors++; $display("FAIL rw_old_b: got %h expected 10304", {b_readdatavalid, b_readdata}); end
    a_chipselect = 1'b1; a_read = 1'b1; a_address = 7;
    b_chipselect = 1'b1; b_write = 1'b1; b_address = 15; b_byteenable = 2'b11; b_writedata = 16'hABCD;
    tick();
    idle();
    repeat (RL - 1) tick();
    checks++;
    if ({a_readdatavalid, a_readdata} !== 33'h1_FFFF_FFFF) begin errors++; $display("FAIL rw_old_a: got %h expected 1ffffffff", {a_readdatavalid, a_readdata}); end
    a_rd(7, v, d);
    checks++;
    if ({v, d} !== 33'h1_ABCD_FFFF) begin errors++; $display("FAIL rw_new: got %h expected 1abcdffff", {v, d}); end
    // read and write together behave as a write with no read response
    pulses = 0;
    a_chipselect = 1'b1; a_read = 1'b1; a_write = 1'b1; a_address = 8; a_byteenable = 4'hF; a_writedata = 32'h55;
    tick();
    idle();
    for (int k = 0; k < 4; k++) begin note_a_pulse(); tick(); end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL rdwr_no_valid: got %0d pulses expected 0", pulses); end
    a_rd(8, v, d);
    checks++;
    if ({v, d} !== 33'h1_0000_0055) begin errors++; $display("FAIL rdwr_write: got %h expected 100000055", {v, d}); end
  endtask

`ifndef DIRCC_PMEM_ZERO_INIT_EN
  task automatic test_oor();
    logic v; logic [15:0] h;
    checks++;
    if (err_oor !== 1'b0) begin errors++; $display("FAIL oor_pre: got %b expected 0", err_oor); end
    b_rd(14'd10000, v, h);
    checks++;
    if ({v, h} !== 17'h1_0000) begin errors++; $display("FAIL oor_read: got %h expected 10000", {v, h}); end
    checks++;
    if (err_oor !== 1'b1) begin errors++; $display("FAIL oor_flag: got %b expected 1", err_oor); end
    repeat (5) tick();
    checks++;
    if (err_oor !== 1'b1) begin errors++; $display("FAIL oor_sticky: got %b expected 1", err_oor); end
  endtask
`endif

  task automatic test_freeze();
    logic frozen_ok = 1'b1;
    pulses = 0;
    a_chipselect = 1'b1; a_read = 1'b1; a_address = 3;
    tick();
    note_a_pulse();
    a_address = 4; freeze = 1'b1;
    #1;
    checks++;
    if (a_waitrequest !== 1'b0) begin errors++; $display("FAIL freeze_lag: got %b expected 0", a_waitrequest); end
    tick();
    note_a_pulse();
    a_address = 5;
    for (int k = 0; k < 4; k++) begin
      if (a_waitrequest !== 1'b1 || b_waitrequest !== 1'b1) frozen_ok = 1'b0;
      tick();
      note_a_pulse();
    end
    checks++;
    if (frozen_ok !== 1'b1) begin errors++; $display("FAIL freeze_wait: got %b expected 1", frozen_ok); end
    freeze = 1'b0;
    idle();
    tick();
    note_a_pulse();
    checks++;
    if (a_waitrequest !== 1'b0) begin errors++; $display("FAIL unfreeze: got %b expected 0", a_waitrequest); end
    checks++;
    if (pulses != 2) begin errors++; $display("FAIL freeze_pulses: got %0d expected 2", pulses); end
    checks++;
    if ({pulse_data[0], pulse_data[1]} !== 64'hDEAD_BEEF_12BB_00DD) begin
      errors++; $display("FAIL freeze_data: got %h %h expected deadbeef 12bb00dd", pulse_data[0], pulse_data[1]);
    end
  endtask

  task automatic test_reset_preserve();
    logic v; logic [31:0] d;
    a_wr(2, 4'hF, 32'hCAFE_F00D);
    a_chipselect = 1'b1; a_read = 1'b1; a_address = 2;
    tick();
    idle();
    reset_n = 1'b0;
    #1;
    checks++;
    if ({a_readdatavalid, a_waitrequest, init_done, err_oor} !== 4'b0100) begin
      errors++; $display("FAIL rst2_ctrl: got %b expected 0100", {a_readdatavalid, a_waitrequest, init_done, err_oor});
    end
    checks++;
    if (a_readdata !== 32'h0) begin errors++; $display("FAIL rst2_rdata: got %h expected 0", a_readdata); end
    tick(); tick();
    pulses = 0;
    release_reset();
    for (int k = 0; k < 3; k++) begin note_a_pulse(); tick(); end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL rst2_discard: got %0d pulses expected 0", pulses); end
    a_rd(2, v, d);
    checks++;
    if ({v, d} !== {1'b1, PRESERVED}) begin errors++; $display("FAIL rst2_contents: got %h expected 1%h", {v, d}, PRESERVED); end
  endtask

  initial begin
    test_reset();
`ifdef DIRCC_PMEM_ZERO_INIT_EN
    test_zero_fill();
`endif
    test_back_to_back();
    test_byte_enable();
    test_conflict();
    test_rw_same_cycle();
`ifndef DIRCC_PMEM_ZERO_INIT_EN
    test_oor();
`endif
    test_freeze();
    test_reset_preserve();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
